mdio_phy_slave: RTL and testbench
=================================

Name: mdio_phy_slave

Overview: Clause-22 MDIO management responder, the PHY-side end of the MDC/MDIO link driven by the station-management master. It oversamples MDC/MDIO on the system clock, hunts preamble, and decodes ST/OP/PHYAD/REGAD/TA/DATA. It writes an internal register file on write frames and drives read data back onto MDIO on read frames. It sits in the PHY model and loopback bench, so that master write sequences can be checked and read-back exercised.

Parameters:
PHY_ADDR, 5'b10000, PHY address this responder answers to
NUM_REGS, 32, implemented registers at addresses 0..NUM_REGS-1 (1..32)
PRE_LEN, 32, minimum consecutive 1 bits accepted as preamble

Ports:
clk  input  1  system clock; must be at least 4x MDC frequency
rst  input  1  asynchronous, active-high reset
mdc  input  1  management clock from master, asynchronous to clk
mdio_i  input  1  MDIO pad input
mdio_o  output  1  MDIO drive value
mdio_oe  output  1  MDIO output enable; pad is high-Z when 0
reg_wr_stb  output  1  one-clk pulse when a register is written
reg_wr_addr  output  5  address of the write
reg_wr_data  output  16  data of the write
frame_err  output  1  one-clk pulse on a bad ST/OP after a valid preamble

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, preamble count=0, mdio_oe=0, mdio_o=1.
  - reg_wr_stb=0, reg_wr_addr=0, reg_wr_data=0, frame_err=0.
  - All registers are 16'h0000.
  - Reset mid-frame aborts the frame immediately and releases MDIO.
- Sampling:
  - mdc and mdio_i each pass through a 2-flop synchronizer.
  - MDC rising edge = synced mdc 0->1, a one-clk "tick".
  - On each tick the synced mdio is the received bit.
  - All outputs update on the clk after the tick.
- Bit order: all fields MSB first.
  - ST=01.
  - OP: 01 = write, 10 = read.
  - Write TA=10.
- States:
  - IDLE: count consecutive 1 bits, saturating at PRE_LEN. A 0 bit with count>=PRE_LEN -> START (this 0 is ST bit 1). A 0 bit with count<PRE_LEN -> count=0, stay.
  - START: expect 1. Got 1 -> OP. Got 0 -> frame_err, IDLE with count=0.
  - OP: 2 bits. 01 or 10 -> PHYAD. 00 or 11 -> frame_err, IDLE with count=0.
  - PHYAD: 5 bits, then REGAD.
  - REGAD: 5 bits. On the last bit:
    - Address mismatch -> SKIP, remaining=18 bits.
    - Read with match -> latch read word, go to TA.
    - Write with match -> TA.
  - TA: 2 bits.
    - Write: received bits are ignored (not checked), then WDATA.
    - Read: mdio_oe stays 0 through TA bit 1. On the tick that samples TA bit 1, drive mdio_o=0, mdio_oe=1, then RDATA.
  - WDATA: shift 16 bits. On the 16th tick:
    - Address < NUM_REGS: write register, pulse reg_wr_stb with addr/data.
    - Otherwise: discard, no strobe.
    - Then IDLE, count=0.
  - RDATA: on each tick drive the next bit D15..D0. On the tick after D0 is sampled: mdio_oe=0, mdio_o=1, IDLE, count=0.
  - SKIP: count down 18 ticks with mdio_oe=0, then IDLE, count=0.
- Read word:
  - Register contents for address < NUM_REGS.
  - 16'hFFFF for unimplemented addresses.
- Register 0 bit 15 (soft reset):
  - A write with bit15=1 writes the data, then clears all registers to 0 on the next clk.
  - Bit15 always reads 0 (self-clearing).
  - reg_wr_stb still reports the written data.
- Back-to-back frames: a new preamble is needed after every frame; a 32-bit preamble is accepted with no idle gap.
- Drive window: mdio_oe is only ever 1 from TA bit 2 through D0 of a matched read.
- MDC stall: all state holds indefinitely while no ticks arrive.

Test Plan:
- 32 ones, write PHYAD=16, REGAD=16, data 16'h0060 -> one reg_wr_stb with addr 16, data 16'h0060. mdio_oe never asserts. Read of reg 16 returns 16'h0060.
- Write reg 20 = 16'h0070, then preamble + read reg 20 -> mdio_oe rises after the TA bit-1 tick. Master samples 0 at TA2, then 16'h0070 MSB first. mdio_oe drops after the D0 tick.
- Write to PHYAD=5'b00001 (mismatch), then a valid write to reg 29 = 16'h0012 -> no strobe for the first frame. Second frame strobes addr 29, data 16'h0012 (SKIP resynchronizes).
- Write reg 0 = 16'h8140 after loading regs 16/20 -> strobe addr 0, data 16'h8140. All registers then read 0, reg 0 reads 16'h0000.
- Only 20 ones then ST, and separately a valid preamble with OP=11 -> no strobe in either case. The OP=11 case pulses frame_err. A following valid write succeeds.
- Assert rst during RDATA bit 8 -> mdio_oe=0 immediately, registers cleared. A subsequent read of reg 16 returns 16'h0000.

Source files
------------

// File: rtl/mdio_if.sv
// MDIO pad and register-write report bundle between station
// management master and the PHY-side responder.
interface mdio_if;
    logic        mdc;
    logic        mdio_i;
    logic        mdio_o;
    logic        mdio_oe;
    logic        reg_wr_stb;
    logic [4:0]  reg_wr_addr;
    logic [15:0] reg_wr_data;
    logic        frame_err;

    modport master (
        output mdc,
        output mdio_i,
        input  mdio_o,
        input  mdio_oe,
        input  reg_wr_stb,
        input  reg_wr_addr,
        input  reg_wr_data,
        input  frame_err
    );

    modport slave (
        input  mdc,
        input  mdio_i,
        output mdio_o,
        output mdio_oe,
        output reg_wr_stb,
        output reg_wr_addr,
        output reg_wr_data,
        output frame_err
    );
endinterface

// File: rtl/mdio_phy_slave.sv
// Clause-22 MDIO responder: oversamples MDC/MDIO on clk, decodes
// frames, owns a small register file and drives read data back.
module mdio_phy_slave #(
    parameter logic [4:0] PHY_ADDR = 5'b10000,
    parameter int          NUM_REGS = 32,
    parameter int          PRE_LEN  = 32
) (
    input logic   clk,
    input logic   rst,
    mdio_if.slave bus
);

    localparam int         PW = $clog2(PRE_LEN + 1);
    localparam logic [5:0] NR = 6'(NUM_REGS);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_OP,
        S_PHYAD,
        S_REGAD,
        S_TA,
        S_WDATA,
        S_RDATA,
        S_SKIP
    } state_t;

    state_t        state_q;
    logic [PW-1:0] pre_q;
    logic [4:0]    cnt_q;
    logic [1:0]    op_q;
    logic [4:0]    phy_q;
    logic [4:0]    regad_q;
    logic [15:0]   sh_q;
    logic [2:0]    mdc_q;
    logic [1:0]    mdio_q;
    logic          oe_q;
    logic          mdo_q;
    logic          stb_q;
    logic [4:0]    waddr_q;
    logic [15:0]   wdata_q;
    logic          ferr_q;
    logic          srst_q;
    logic [15:0]   regs_q [NUM_REGS];

    logic        tick;
    logic        rbit;
    logic [4:0]  raddr_d;
    logic [15:0] rword_d;
    logic [15:0] wword_d;
    logic        whit_d;

    assign tick = mdc_q[1] & ~mdc_q[2];
    assign rbit = mdio_q[1];

    assign bus.mdio_o      = mdo_q;
    assign bus.mdio_oe     = oe_q;
    assign bus.reg_wr_stb  = stb_q;
    assign bus.reg_wr_addr = waddr_q;
    assign bus.reg_wr_data = wdata_q;
    assign bus.frame_err   = ferr_q;

    // Register 0 bit 15 is a self-clearing soft reset and reads 0.
    always_comb begin
        raddr_d = {regad_q[3:0], rbit};
        rword_d = 16'hFFFF;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (raddr_d == 5'(i)) begin
                rword_d = regs_q[i];
                if (i == 0) rword_d[15] = 1'b0;
            end
        end
        wword_d = {sh_q[14:0], rbit};
        whit_d  = {1'b0, regad_q} < NR;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pre_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            phy_q   <= '0;
            regad_q <= '0;
            sh_q    <= '0;
            mdc_q   <= '0;
            mdio_q  <= '0;
            oe_q    <= 1'b0;
            mdo_q   <= 1'b1;
            stb_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            ferr_q  <= 1'b0;
            srst_q  <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            mdc_q  <= {mdc_q[1:0], bus.mdc};
            mdio_q <= {mdio_q[0], bus.mdio_i};
            stb_q  <= 1'b0;
            ferr_q <= 1'b0;
            srst_q <= 1'b0;
            if (srst_q) begin
                for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            end
            if (tick) begin
                unique case (state_q)
                    S_IDLE: begin
                        if (rbit) begin
                            if (pre_q < PW'(PRE_LEN)) pre_q <= pre_q + 1'b1;
                        end else begin
                            if (pre_q >= PW'(PRE_LEN)) state_q <= S_START;
                            pre_q <= '0;
                        end
                    end
                    S_START: begin
                        cnt_q <= '0;
                        if (rbit) begin
                            state_q <= S_OP;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end
                    S_OP: begin
                        op_q <= {op_q[0], rbit};
                        if (cnt_q == 5'd1) begin
                            cnt_q <= '0;
                            if (op_q[0] != rbit) begin
                                state_q <= S_PHYAD;
                            end else begin
                                ferr_q  <= 1'b1;
                                state_q <= S_IDLE;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    S_PHYAD: begin
                        phy_q <= {phy_q[3:0], rbit};
                        if (cnt_q == 5'd4) begin
                            cnt_q   <= '0;
                            state_q <= S_REGAD;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    S_REGAD: begin
                        regad_q <= raddr_d;
                        if (cnt_q == 5'd4) begin
                            cnt_q <= '0;
                            if (phy_q != PHY_ADDR) begin
                                state_q <= S_SKIP;
                            end else begin
                                if (op_q == 2'b10) sh_q <= rword_d;
                                state_q <= S_TA;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    S_TA: begin
                        if (op_q == 2'b10) begin
                            mdo_q   <= 1'b0;
                            oe_q    <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= S_RDATA;
                        end else if (cnt_q == 5'd1) begin
                            cnt_q   <= '0;
                            state_q <= S_WDATA;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    S_WDATA: begin
                        sh_q <= wword_d;
                        if (cnt_q == 5'd15) begin
                            cnt_q   <= '0;
                            state_q <= S_IDLE;
                            if (whit_d) begin
                                for (int i = 0; i < NUM_REGS; i++) begin
                                    if (regad_q == 5'(i)) regs_q[i] <= wword_d;
                                end
                                stb_q   <= 1'b1;
                                waddr_q <= regad_q;
                                wdata_q <= wword_d;
                                srst_q  <= (regad_q == 5'd0) & wword_d[15];
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    // Slot 16 is the D0 bit time: release the pad.
                    S_RDATA: begin
                        if (cnt_q == 5'd16) begin
                            oe_q    <= 1'b0;
                            mdo_q   <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= S_IDLE;
                        end else begin
                            mdo_q <= sh_q[15];
                            sh_q  <= {sh_q[14:0], 1'b0};
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    S_SKIP: begin
                        if (cnt_q == 5'd17) begin
                            cnt_q   <= '0;
                            state_q <= S_IDLE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mdio_phy_slave.sv
// Directed bench for mdio_phy_slave: master-side MDC/MDIO driver with
// per-scenario tasks and inline checks.
module tb_mdio_phy_slave;

    logic clk;
    logic rst;
    mdio_if bus ();

    mdio_phy_slave #(
        .PHY_ADDR (5'b10000),
        .NUM_REGS (32),
        .PRE_LEN  (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    int          stb_tot = 0;
    int          ferr_tot = 0;
    int          oe_tot = 0;
    logic [4:0]  last_addr = '0;
    logic [15:0] last_data = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.reg_wr_stb) begin
            stb_tot++;
            last_addr = bus.reg_wr_addr;
            last_data = bus.reg_wr_data;
        end
        if (bus.frame_err) ferr_tot++;
        if (bus.mdio_oe) oe_tot++;
    end

    // One MDC bit: master sets MDIO while MDC is low, pad sampled
    // just before the rising edge (pull-up when released).
    task automatic bit_io(input logic b, output logic s, output logic o);
        bus.mdio_i = b;
        #20;
        o = bus.mdio_oe;
        s = bus.mdio_oe ? bus.mdio_o : 1'b1;
        bus.mdc = 1'b1;
        #40;
        bus.mdc = 1'b0;
        #20;
    endtask

    task automatic do_frame(
        input  int          pre,
        input  logic [1:0]  op,
        input  logic [4:0]  phy,
        input  logic [4:0]  ra,
        input  logic [15:0] wd,
        output logic [15:0] rd,
        output logic        oe_pre,
        output logic [1:0]  ta
    );
        logic s, o, rdf;
        logic [13:0] h;
        rdf = (op == 2'b10);
        h = {2'b01, op, phy, ra};
        rd = '0;
        oe_pre = 1'b0;
        repeat (pre) begin
            bit_io(1'b1, s, o);
            oe_pre |= o;
        end
        for (int i = 13; i >= 0; i--) begin
            bit_io(h[i], s, o);
            oe_pre |= o;
        end
        bit_io(1'b1, s, o);
        oe_pre |= o;
        bit_io(rdf ? 1'b1 : 1'b0, s, o);
        ta = {o, s};
        for (int i = 15; i >= 0; i--) begin
            bit_io(rdf ? 1'b1 : wd[i], s, o);
            rd[i] = s;
        end
    endtask

    task automatic wr(input logic [4:0] phy, input logic [4:0] ra,
                      input logic [15:0] d);
        logic [15:0] r;
        logic e;
        logic [1:0] t;
        do_frame(32, 2'b01, phy, ra, d, r, e, t);
    endtask

    task automatic rd_reg(input logic [4:0] ra, output logic [15:0] r);
        logic e;
        logic [1:0] t;
        do_frame(32, 2'b10, 5'd16, ra, 16'h0000, r, e, t);
    endtask

    task automatic test_reset;
        n_cmp++;
        if (bus.mdio_oe !== 1'b0) begin
            n_err++;
            $display("FAIL rst_oe: got %b want 0", bus.mdio_oe);
        end
        n_cmp++;
        if (bus.mdio_o !== 1'b1) begin
            n_err++;
            $display("FAIL rst_o: got %b want 1", bus.mdio_o);
        end
        n_cmp++;
        if (bus.reg_wr_stb !== 1'b0) begin
            n_err++;
            $display("FAIL rst_stb: got %b want 0", bus.reg_wr_stb);
        end
        n_cmp++;
        if (bus.reg_wr_addr !== 5'd0) begin
            n_err++;
            $display("FAIL rst_addr: got %h want 00", bus.reg_wr_addr);
        end
        n_cmp++;
        if (bus.reg_wr_data !== 16'h0000) begin
            n_err++;
            $display("FAIL rst_data: got %h want 0000", bus.reg_wr_data);
        end
        n_cmp++;
        if (bus.frame_err !== 1'b0) begin
            n_err++;
            $display("FAIL rst_ferr: got %b want 0", bus.frame_err);
        end
    endtask

    task automatic test_write;
        int s0, o0;
        logic [15:0] r;
        s0 = stb_tot;
        o0 = oe_tot;
        wr(5'd16, 5'd16, 16'h0060);
        n_cmp++;
        if (stb_tot - s0 !== 1) begin
            n_err++;
            $display("FAIL wr_stb_cnt: got %0d want 1", stb_tot - s0);
        end
        n_cmp++;
        if (last_addr !== 5'd16) begin
            n_err++;
            $display("FAIL wr_addr: got %0d want 16", last_addr);
        end
        n_cmp++;
        if (last_data !== 16'h0060) begin
            n_err++;
            $display("FAIL wr_data: got %h want 0060", last_data);
        end
        n_cmp++;
        if (oe_tot - o0 !== 0) begin
            n_err++;
            $display("FAIL wr_oe: got %0d oe clks want 0", oe_tot - o0);
        end
        rd_reg(5'd16, r);
        n_cmp++;
        if (r !== 16'h0060) begin
            n_err++;
            $display("FAIL rd16: got %h want 0060", r);
        end
    endtask

    task automatic test_read;
        logic [15:0] r;
        logic e;
        logic [1:0] t;
        wr(5'd16, 5'd20, 16'h0070);
        do_frame(32, 2'b10, 5'd16, 5'd20, 16'h0000, r, e, t);
        n_cmp++;
        if (e !== 1'b0) begin
            n_err++;
            $display("FAIL rd_oe_early: got %b want 0", e);
        end
        n_cmp++;
        if (t !== 2'b10) begin
            n_err++;
            $display("FAIL rd_ta2: got oe/pad %b want 10", t);
        end
        n_cmp++;
        if (r !== 16'h0070) begin
            n_err++;
            $display("FAIL rd20: got %h want 0070", r);
        end
        n_cmp++;
        if (bus.mdio_oe !== 1'b0) begin
            n_err++;
            $display("FAIL rd_release: got %b want 0", bus.mdio_oe);
        end
    endtask

    task automatic test_phy_mismatch;
        int s0;
        s0 = stb_tot;
        wr(5'b00001, 5'd29, 16'hFFFF);
        n_cmp++;
        if (stb_tot - s0 !== 0) begin
            n_err++;
            $display("FAIL skip_stb: got %0d want 0", stb_tot - s0);
        end
        wr(5'd16, 5'd29, 16'h0012);
        n_cmp++;
        if (stb_tot - s0 !== 1) begin
            n_err++;
            $display("FAIL resync_stb: got %0d want 1", stb_tot - s0);
        end
        n_cmp++;
        if (last_addr !== 5'd29) begin
            n_err++;
            $display("FAIL resync_addr: got %0d want 29", last_addr);
        end
        n_cmp++;
        if (last_data !== 16'h0012) begin
            n_err++;
            $display("FAIL resync_data: got %h want 0012", last_data);
        end
    endtask

    task automatic test_soft_reset;
        int s0;
        logic [15:0] r;
        wr(5'd16, 5'd16, 16'h1111);
        wr(5'd16, 5'd20, 16'h2222);
        s0 = stb_tot;
        wr(5'd16, 5'd0, 16'h8140);
        n_cmp++;
        if (stb_tot - s0 !== 1) begin
            n_err++;
            $display("FAIL srst_stb: got %0d want 1", stb_tot - s0);
        end
        n_cmp++;
        if (last_addr !== 5'd0 || last_data !== 16'h8140) begin
            n_err++;
            $display("FAIL srst_wr: got %0d/%h want 0/8140",
                     last_addr, last_data);
        end
        rd_reg(5'd0, r);
        n_cmp++;
        if (r !== 16'h0000) begin
            n_err++;
            $display("FAIL srst_rd0: got %h want 0000", r);
        end
        rd_reg(5'd16, r);
        n_cmp++;
        if (r !== 16'h0000) begin
            n_err++;
            $display("FAIL srst_rd16: got %h want 0000", r);
        end
        rd_reg(5'd20, r);
        n_cmp++;
        if (r !== 16'h0000) begin
            n_err++;
            $display("FAIL srst_rd20: got %h want 0000", r);
        end
    endtask

    task automatic test_bad_frames;
        int s0, f0;
        logic [15:0] r;
        logic e;
        logic [1:0] t;
        s0 = stb_tot;
        f0 = ferr_tot;
        do_frame(20, 2'b01, 5'd16, 5'd5, 16'h0000, r, e, t);
        n_cmp++;
        if (stb_tot - s0 !== 0) begin
            n_err++;
            $display("FAIL short_pre_stb: got %0d want 0", stb_tot - s0);
        end
        n_cmp++;
        if (ferr_tot - f0 !== 0) begin
            n_err++;
            $display("FAIL short_pre_ferr: got %0d want 0", ferr_tot - f0);
        end
        do_frame(32, 2'b11, 5'd16, 5'd5, 16'h0000, r, e, t);
        n_cmp++;
        if (stb_tot - s0 !== 0) begin
            n_err++;
            $display("FAIL op11_stb: got %0d want 0", stb_tot - s0);
        end
        n_cmp++;
        if (ferr_tot - f0 !== 1) begin
            n_err++;
            $display("FAIL op11_ferr: got %0d want 1", ferr_tot - f0);
        end
        wr(5'd16, 5'd5, 16'h1234);
        n_cmp++;
        if (stb_tot - s0 !== 1) begin
            n_err++;
            $display("FAIL recov_stb: got %0d want 1", stb_tot - s0);
        end
        n_cmp++;
        if (last_addr !== 5'd5 || last_data !== 16'h1234) begin
            n_err++;
            $display("FAIL recov_wr: got %0d/%h want 5/1234",
                     last_addr, last_data);
        end
    endtask

    task automatic test_reset_mid_read;
        logic s, o;
        logic [13:0] h;
        logic [15:0] r;
        wr(5'd16, 5'd16, 16'hBEEF);
        h = {2'b01, 2'b10, 5'd16, 5'd16};
        repeat (32) bit_io(1'b1, s, o);
        for (int i = 13; i >= 0; i--) bit_io(h[i], s, o);
        repeat (2) bit_io(1'b1, s, o);
        repeat (8) bit_io(1'b1, s, o);
        n_cmp++;
        if (o !== 1'b1) begin
            n_err++;
            $display("FAIL mid_rd_oe: got %b want 1", o);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.mdio_oe !== 1'b0 || bus.mdio_o !== 1'b1) begin
            n_err++;
            $display("FAIL mid_rst_pad: got oe=%b o=%b want 0/1",
                     bus.mdio_oe, bus.mdio_o);
        end
        #19;
        rst = 1'b0;
        #20;
        rd_reg(5'd16, r);
        n_cmp++;
        if (r !== 16'h0000) begin
            n_err++;
            $display("FAIL post_rst_rd16: got %h want 0000", r);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.mdc = 1'b0;
        bus.mdio_i = 1'b1;
        #32;
        test_reset;
        rst = 1'b0;
        #20;
        test_write;
        test_read;
        test_phy_mismatch;
        test_soft_reset;
        test_bad_frames;
        test_reset_mid_read;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
